// File: rtl/prio_grant_pkg.sv
// Shared widths, code constants, sequencer state encoding and code decode helper.
package prio_grant_pkg;

  localparam int CODE_W    = 3;
  localparam int NUM_LINES = 4;

  localparam logic [CODE_W-1:0] CODE_NONE      = 3'd0;
  localparam logic [CODE_W-1:0] CODE_MAX_VALID = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  // Line n (1..4) maps to bit n-1; anything else decodes to no grant.
  function automatic logic [NUM_LINES-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [NUM_LINES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (code == CODE_W'(i + 1)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/prio_grant_fifo.sv
// Small synchronous FIFO of request codes; pointers wrap naturally since DEPTH is a power of two.
module prio_grant_fifo
  import prio_grant_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [CODE_W-1:0]      push_dat_i,
  input  logic                   pop_i,
  output logic [CODE_W-1:0]      pop_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    level_q;
  logic              do_push, do_pop;

  assign full_o    = (level_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/prio_grant_sequencer.sv
// Buffers encoded request codes and replays them as held one-hot grants with a one-cycle gap.
// Optional saturating error counter output enabled by PRIO_GRANT_ERR_CNT_EN.
module prio_grant_sequencer
  import prio_grant_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CODE_W-1:0]      code_in,
  input  logic                   code_valid,
  output logic                   code_ready,
  output logic [NUM_LINES:1]     grant,
  output logic                   grant_active,
  output logic                   grant_done,
  output logic                   err_code,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef PRIO_GRANT_ERR_CNT_EN
  ,
  output logic [7:0]             err_count
`endif
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_LINES-1:0] grant_q;
  logic                 done_q;
  logic                 err_code_q, err_code_d;

  logic                 accept, is_err, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [CODE_W-1:0]    fifo_dat;

  assign accept     = code_valid && code_ready;
  assign is_err     = (code_in > CODE_MAX_VALID);
  assign push       = accept && (code_in != CODE_NONE) && !is_err;
  assign err_code_d = accept && is_err;
  // A pop is taken on the edge that leaves IDLE or GAP toward GRANT.
  assign pop        = ((state_q == IDLE) || (state_q == GAP)) && !fifo_empty;

  prio_grant_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (push),
    .push_dat_i(code_in),
    .pop_i     (pop),
    .pop_dat_o (fifo_dat),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (!fifo_empty) begin
            grant_q <= code_to_onehot(fifo_dat);
            cnt_q   <= HOLD_INIT;
            state_q <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (cnt_q == '0) begin
            grant_q <= '0;
            done_q  <= 1'b1;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_code_q <= 1'b0;
    else          err_code_q <= err_code_d;
  end

  assign code_ready   = !fifo_full;
  assign grant        = grant_q;
  assign grant_active = |grant_q;
  assign grant_done   = done_q;
  assign err_code     = err_code_q;

`ifdef PRIO_GRANT_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            err_cnt_q <= '0;
    else if (err_code_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_prio_grant_sequencer.sv
// Directed bench: per-cycle vector table plus hand sequences for stall, reset and GAP overlap.
module tb_prio_grant_sequencer;

  logic       clk;
  logic       reset_n;
  logic [2:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic [4:1] grant;
  logic       grant_active;
  logic       grant_done;
  logic       err_code;
  logic [2:0] fifo_level;
`ifdef PRIO_GRANT_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  prio_grant_sequencer #(
    .DEPTH      (4),
    .HOLD_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .grant       (grant),
    .grant_active(grant_active),
    .grant_done  (grant_done),
    .err_code    (err_code),
    .fifo_level  (fifo_level)
`ifdef PRIO_GRANT_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [2:0] code;
    logic [3:0] g;
    logic       done;
    logic       err;
    logic       rdy;
    logic [2:0] lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vld, input logic [2:0] code, input logic [3:0] g,
                     input logic done, input logic err, input logic rdy, input logic [2:0] lvl);
    vec_t v;
    v.vld = vld; v.code = code; v.g = g; v.done = done; v.err = err; v.rdy = rdy; v.lvl = lvl;
    vecs.push_back(v);
  endtask

  // Continuous invariant checks and capture of each new grant onset.
  logic [3:0] prev_g = 4'b0;
  int         got[$];

  always @(posedge clk) begin
    #1;
    chk("inv_active", int'(grant_active), int'(|grant));
    chk("inv_onehot", int'($onehot0(grant)), 1);
    chk("inv_done_excl", int'(grant_done && (grant != 4'b0)), 0);
    chk("inv_bbm", int'((prev_g != 4'b0) && (grant != 4'b0) && (grant != prev_g)), 0);
    chk("inv_level_max", int'(fifo_level > 3'd4), 0);
    if (grant != 4'b0 && prev_g == 4'b0) got.push_back(int'(grant));
    prev_g = grant;
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    code_valid = 1'b0;
    code_in = 3'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [2:0] c);
    int n;
    n = 0;
    @(negedge clk);
    code_valid = 1'b1;
    code_in = c;
    while (!code_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  initial begin
    int n;
    int exp_order[6];
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_order[6];
    reset_n = 1'b0;
    code_valid = 1'b0;
    code_in = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_active", int'(grant_active), 0);
    chk("rst_done", int'(grant_done), 0);
    chk("rst_err", int'(err_code), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ready", int'(code_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single code 3.
    add(1, 3, 4'b0000, 0, 0, 1, 1);
    add(0, 0, 4'b0100, 0, 0, 1, 0);
    add(0, 0, 4'b0100, 0, 0, 1, 0);
    add(0, 0, 4'b0100, 0, 0, 1, 0);
    add(0, 0, 4'b0100, 0, 0, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 1, 0);
    add(0, 0, 4'b0000, 0, 0, 1, 0);
    // Code 0 discarded, code 6 discarded with error pulse.
    add(1, 0, 4'b0000, 0, 0, 1, 0);
    add(1, 6, 4'b0000, 0, 1, 1, 0);
    add(0, 0, 4'b0000, 0, 0, 1, 0);
    // Codes 1, 2, 4 back to back.
    add(1, 1, 4'b0000, 0, 0, 1, 1);
    add(1, 2, 4'b0001, 0, 0, 1, 1);
    add(1, 4, 4'b0001, 0, 0, 1, 2);
    add(0, 0, 4'b0001, 0, 0, 1, 2);
    add(0, 0, 4'b0001, 0, 0, 1, 2);
    add(0, 0, 4'b0000, 1, 0, 1, 2);
    add(0, 0, 4'b0010, 0, 0, 1, 1);
    add(0, 0, 4'b0010, 0, 0, 1, 1);
    add(0, 0, 4'b0010, 0, 0, 1, 1);
    add(0, 0, 4'b0010, 0, 0, 1, 1);
    add(0, 0, 4'b0000, 1, 0, 1, 1);
    add(0, 0, 4'b1000, 0, 0, 1, 0);
    add(0, 0, 4'b1000, 0, 0, 1, 0);
    add(0, 0, 4'b1000, 0, 0, 1, 0);
    add(0, 0, 4'b1000, 0, 0, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 1, 0);
    add(0, 0, 4'b0000, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      code_valid = vecs[i].vld;
      code_in = vecs[i].code;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].g));
      chk($sformatf("vec%0d_done", i), int'(grant_done), int'(vecs[i].done));
      chk($sformatf("vec%0d_err", i), int'(err_code), int'(vecs[i].err));
      chk($sformatf("vec%0d_ready", i), int'(code_ready), int'(vecs[i].rdy));
      chk($sformatf("vec%0d_level", i), int'(fifo_level), int'(vecs[i].lvl));
    end
    @(negedge clk);
    code_valid = 1'b0;
`ifdef PRIO_GRANT_ERR_CNT_EN
    chk("err_count_one", int'(err_count), 1);
`endif

    // Six codes while the first grant is active: stall at full, order preserved.
    do_reset();
    got.delete();
    send(3'd1);
    send(3'd2);
    send(3'd3);
    send(3'd4);
    send(3'd1);
    chk("stall_level", int'(fifo_level), 4);
    chk("stall_ready", int'(code_ready), 0);
    send(3'd2);
    n = 0;
    while (!(got.size() == 6 && grant == 4'b0 && fifo_level == 3'd0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_drain_timeout", int'(n >= 400), 0);
    exp_order = '{1, 2, 4, 8, 1, 2};
    chk("stall_grant_count", got.size(), 6);
    foreach (exp_order[i]) begin
      chk($sformatf("stall_order%0d", i), (i < got.size()) ? got[i] : -1, exp_order[i]);
    end

    // Reset mid-grant with two entries queued.
    do_reset();
    send(3'd1);
    send(3'd2);
    send(3'd3);
    chk("mid_level_before", int'(fifo_level), 2);
    chk("mid_grant_before", int'(grant), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_grant_async", int'(grant), 0);
    chk("mid_active_async", int'(grant_active), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    got.delete();
    repeat (20) @(posedge clk);
    #1;
    chk("mid_level_after", int'(fifo_level), 0);
    chk("mid_ready_after", int'(code_ready), 1);
    chk("mid_no_grants", got.size(), 0);

    // Push and pop on the edge that ends the GAP cycle.
    do_reset();
    send(3'd1);
    send(3'd2);
    send(3'd3);
    n = 0;
    while (!grant_done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("gap_reach_timeout", int'(n >= 20), 0);
    chk("gap_level_before", int'(fifo_level), 2);
    chk("gap_grant_zero", int'(grant), 0);
    @(negedge clk);
    code_valid = 1'b1;
    code_in = 3'd4;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    chk("gap_level_same", int'(fifo_level), 2);
    chk("gap_next_grant", int'(grant), 2);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
